// File: rtl/mem_burst_reader.sv
// Burst read engine for the single-port synchronous memory: issues sequential
// wrapping reads and streams the returned words through a 3-entry valid/ready FIFO.
module mem_burst_reader #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 128,
    parameter int ADDR_W = $clog2(SIZE),
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int CNT_W = LEN_W + 1;
    localparam logic [ADDR_W:0]   SIZE_L    = (ADDR_W+1)'(SIZE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  issue_addr_q, issue_addr_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
    logic [CNT_W-1:0]   issue_left_q, issue_left_d;
    logic [CNT_W-1:0]   beat_left_q, beat_left_d;
    logic               pending_q;
    logic               cmd_err_q, cmd_err_d;

    logic [WIDTH-1:0]   fifo_q [0:2];
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         cnt_q, cnt_d;

    logic cmd_fire;
    logic addr_ok;
    logic credit_ok;
    logic rd_fire;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued if the FIFO can hold it plus the one in flight.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        cmd_fire  = cmd_valid && cmd_ready;
        addr_ok   = ({1'b0, cmd_addr} < SIZE_L);
        credit_ok = (({1'b0, cnt_q} + {2'b00, pending_q}) <= 3'd2);
        rd_fire   = (state_q == RUN) && (issue_left_q != '0) && credit_ok;
        push      = pending_q;
        out_valid = (cnt_q != 2'd0);
        pop       = out_valid && out_ready;
        out_last  = out_valid && (beat_left_q == CNT_ONE);
        out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
        mem_rd_en   = rd_fire;
        mem_rd_addr = rd_fire ? issue_addr_q : last_addr_q;
        cmd_err     = cmd_err_q;
    end

    always_comb begin
        state_d      = state_q;
        issue_addr_d = issue_addr_q;
        last_addr_d  = last_addr_q;
        issue_left_d = issue_left_q;
        beat_left_d  = beat_left_q;
        cmd_err_d    = 1'b0;

        if (rd_fire) begin
            issue_addr_d = (issue_addr_q == ADDR_LAST) ? '0 : issue_addr_q + 1'b1;
            issue_left_d = issue_left_q - CNT_ONE;
            last_addr_d  = issue_addr_q;
        end
        if (pop) begin
            beat_left_d = beat_left_q - CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_fire && addr_ok) begin
                    state_d      = RUN;
                    issue_addr_d = cmd_addr;
                    issue_left_d = {1'b0, cmd_len} + CNT_ONE;
                    beat_left_d  = {1'b0, cmd_len} + CNT_ONE;
                end else if (cmd_fire) begin
                    cmd_err_d = 1'b1;
                end
            end
            RUN: begin
                if (rd_fire && (issue_left_q == CNT_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_addr_q <= '0;
            last_addr_q  <= '0;
            issue_left_q <= '0;
            beat_left_q  <= '0;
            pending_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            issue_addr_q <= issue_addr_d;
            last_addr_q  <= last_addr_d;
            issue_left_q <= issue_left_d;
            beat_left_q  <= beat_left_d;
            pending_q    <= rd_fire;
            cmd_err_q    <= cmd_err_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed + randomized bench for mem_burst_reader against a memory model
// and a queue-based reference of the expected read and beat sequences.
module tb_mem_burst_reader;

    localparam int WIDTH  = 32;
    localparam int SIZE   = 100;
    localparam int ADDR_W = 7;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_err;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [WIDTH-1:0]  mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic              busy;

    logic [WIDTH-1:0]  mem [SIZE];

    int n_assert = 0;
    int n_fail   = 0;

    mem_burst_reader #(
        .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en && (int'(mem_rd_addr) < SIZE)) begin
            mem_rd_data <= mem[mem_rd_addr];
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_cmd_err"}, cmd_err, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_rd_addr"}, mem_rd_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,...
    task automatic run_burst(input int a, input int len, input int mode,
                             input bit poke);
        int          exp_addr[$];
        logic [31:0] exp_data[$];
        int          issued = 0;
        int          popped = 0;
        int          j = 0;
        int          budget = 6 * (len + 1) + 20;
        bit          done = 0;
        bit          stall_prev = 0;
        logic [31:0] stall_data = '0;
        for (int k = 0; k <= len; k++) begin
            exp_addr.push_back((a + k) % SIZE);
            exp_data.push_back(mem[(a + k) % SIZE]);
        end
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 7'(a);
        cmd_len   = 8'(len);
        out_ready = 1'b0;
        while (!done && j < budget) begin
            @(negedge clk);
            j++;
            cmd_valid = poke && (j == 1);
            if (poke && j == 1) begin
                cmd_addr = 7'($urandom_range(0, SIZE - 1));
                cmd_len  = 8'($urandom);
            end
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 2) out_ready = ((j % 3) == 1);
            else out_ready = 1'($urandom_range(0, 1));
            if (mem_rd_en) begin
                if (issued <= len)
                    chk("rd_addr", mem_rd_addr, exp_addr[issued]);
                else
                    chk("extra_read", 1, 0);
                issued++;
            end
            chk("credit", (issued - popped) <= 3, 1);
            if (mode == 0) begin
                chk("rd_en_timing", mem_rd_en, (j >= 1) && (j <= len + 1));
                chk("valid_timing", out_valid, (j >= 3) && (j <= len + 3));
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, stall_data);
            end
            if (popped == len + 1) begin
                chk("ready_after", cmd_ready, 1);
                chk("busy_after", busy, 0);
                chk("valid_after", out_valid, 0);
                if (mode == 0) chk("ready_cycle", j, len + 4);
                done = 1;
            end else begin
                chk("cmd_ready_busy", cmd_ready, 0);
                chk("busy", busy, 1);
                if (out_valid) begin
                    chk("last", out_last, popped == len);
                    if (out_ready) begin
                        chk("data", out_data, exp_data[popped]);
                        popped++;
                    end
                end else begin
                    chk("last_low", out_last, 0);
                end
            end
            stall_prev = out_valid && !out_ready && !done;
            stall_data = out_data;
        end
        if (!done) chk("timeout", 0, 1);
        chk("beats", popped, len + 1);
        chk("reads", issued, len + 1);
        cmd_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_error(input int a);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 7'(a);
        cmd_len   = 8'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_pulse", cmd_err, 1);
        chk("err_busy", busy, 0);
        chk("err_rd_en", mem_rd_en, 0);
        chk("err_ready", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_clear", cmd_err, 0);
            chk("err_no_read", mem_rd_en, 0);
            chk("err_idle", busy, 0);
        end
    endtask

    task automatic run_reset_mid(input int a);
        int popped = 0;
        int j = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 7'(a);
        cmd_len   = 8'd15;
        while (popped < 2 && j < 20) begin
            @(negedge clk);
            j++;
            cmd_valid = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
                chk("rm_data", out_data, mem[(a + popped) % SIZE]);
                popped++;
            end
        end
        chk("rm_two_beats", popped, 2);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("rm_reset");
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rm_no_valid", out_valid, 0);
            chk("rm_no_read", mem_rd_en, 0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
        mem_rd_data = '0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        run_burst(10, 3, 0, 0);
        run_burst(98, 3, 0, 0);
        run_burst(99, 1, 0, 0);
        run_burst(0, 7, 2, 0);
        run_error(SIZE);
        run_error($urandom_range(SIZE, 127));
        run_burst(5, 0, 0, 0);
        run_reset_mid(20);
        run_burst(40, 4, 0, 0);
        run_burst($urandom_range(0, SIZE - 1), 255, 0, 0);
        for (int r = 0; r < 12; r++) begin
            run_burst($urandom_range(0, SIZE - 1), $urandom_range(0, 40),
                      $urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end
        run_burst(SIZE - 1, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side burst engine for the single-port synchronous `memory` block (SIZE/WIDTH parameters). It is the reader counterpart of the existing memory write path.
- Accepts a command (start address, beat count), issues sequential reads with address wrap-around, and absorbs the memory's 1-cycle read latency.
- Streams the read data out on a valid/ready interface with full backpressure support, sustaining 1 beat/cycle when the sink is always ready.

Parameters:
- WIDTH, 32, data width in bits.
- SIZE, 128, memory depth in words; any value >= 2, not required to be a power of 2.
- ADDR_W, $clog2(SIZE), address width.
- LEN_W, 8, burst length field width; a burst is cmd_len+1 beats (1..2^LEN_W).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len  in  LEN_W  beats minus one.
- cmd_err  out  1  one-cycle pulse: command rejected.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  WIDTH  memory read data, valid the cycle after mem_rd_en.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts beat.
- out_data  out  WIDTH  output beat data.
- out_last  out  1  final beat of the burst.
- busy  out  1  burst in progress (state != IDLE).

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, FIFO emptied, in-flight read discarded.
  - cmd_ready=1, cmd_err=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - Reset mid-burst aborts the burst; no further beats are produced.
- FSM states:
  - IDLE -> RUN on cmd_valid && cmd_ready with cmd_addr < SIZE.
  - With cmd_addr >= SIZE: stay in IDLE, command consumed, cmd_err=1 for the next cycle only, no reads issued.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> IDLE on the handshake of the out_last beat.
  - cmd_ready = (state==IDLE); it returns to 1 the cycle after the last handshake.
- Command latching: on accept, latch issue_addr=cmd_addr, issue_left=cmd_len+1, and beat_left=cmd_len+1 (each counter LEN_W+1 bits).
- Read issue:
  - mem_rd_en=1 in a RUN cycle iff issue_left>0 and fifo_count + pending <= 2.
  - pending = a read was issued in the previous cycle. The output FIFO holds 3 entries.
  - On issue: issue_addr increments and wraps SIZE-1 -> 0; issue_left decrements.
  - mem_rd_addr holds its last value when mem_rd_en=0.
- Data return: mem_rd_data is pushed into the FIFO at the end of the cycle following mem_rd_en. The FIFO never overflows, by the credit rule above.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last = out_valid && beat_left==1.
  - Beat handshake = out_valid && out_ready: pops the FIFO and decrements beat_left.
  - out_valid, once high, stays high with out_data stable until the handshake.
  - Simultaneous push and pop is allowed and leaves fifo_count unchanged.
- Latency: command accepted in cycle N -> first mem_rd_en in N+1 -> first out_valid in N+3.
- Throughput: with out_ready=1 continuously, one beat per cycle and no bubbles after the first.
- cmd_valid while busy is ignored (cmd_ready=0); the command fields are not sampled.

Test Plan:
- Basic burst: SIZE=128, cmd_addr=10, cmd_len=3, memory[i]=i, out_ready=1 -> beats 10,11,12,13 in cycles N+3..N+6; out_last only on 13; cmd_ready=1 at N+7.
- Wrap-around: cmd_addr=126, cmd_len=3 -> mem_rd_addr 126,127,0,1; output data 126,127,0,1.
- Backpressure: cmd_addr=0, cmd_len=7, out_ready toggled 1,0,0,1,... -> never more than 3 beats buffered; no beat lost or duplicated; out_data stable while stalled; all 8 beats delivered in order.
- Error and min length: cmd_addr=128 -> cmd_err pulse 1 cycle, no mem_rd_en, busy stays 0. Then cmd_addr=5, cmd_len=0 -> single beat 5 with out_last=1.
- Reset mid-burst: rst high for 1 cycle after 2 of 16 beats -> all outputs at reset values next cycle; no further out_valid; a new command is accepted immediately after.
- Max length: cmd_len=255, out_ready=1 -> exactly 256 beats, consecutive, addresses wrapping twice modulo 128.
